// File: rtl/pipeline_hazard_ctrl_if.sv
// Handshake bundle between the scc core datapath and pipeline_hazard_ctrl.
//
// Signals (direction seen from the controller):
//   clk_en          in   core clock enable
//   id_src1/2       in   source registers of the instruction in ID
//   id_use1/2       in   ID instruction reads the matching source
//   ex_is_load      in   EX instruction is a load
//   ex_dest         in   EX destination register
//   ex_branch_taken in   EX resolved a taken branch
//   mem_req         in   data-memory access in progress
//   mem_ready       in   data memory completes this cycle
//   halt_req        in   decoded halt instruction
//   pc_write        out  PC update enable
//   ifid_write      out  IF/ID load enable
//   idex_write      out  ID/EX load enable
//   ifid_flush      out  load NOP into IF/ID
//   idex_flush      out  load NOP into ID/EX
//   halted          out  core halted
//   err_bits        out  sticky errors: [0] memory timeout, [1] branch during flush
//   stall_count     out  saturating stalled-cycle count
//
// master: core side (drives requests). slave: the controller.
interface pipeline_hazard_ctrl_if;
    logic        clk_en;
    logic [3:0]  id_src1;
    logic [3:0]  id_src2;
    logic        id_use1;
    logic        id_use2;
    logic        ex_is_load;
    logic [3:0]  ex_dest;
    logic        ex_branch_taken;
    logic        mem_req;
    logic        mem_ready;
    logic        halt_req;
    logic        pc_write;
    logic        ifid_write;
    logic        idex_write;
    logic        ifid_flush;
    logic        idex_flush;
    logic        halted;
    logic [1:0]  err_bits;
    logic [15:0] stall_count;

    modport master (
        output clk_en, id_src1, id_src2, id_use1, id_use2, ex_is_load, ex_dest,
               ex_branch_taken, mem_req, mem_ready, halt_req,
        input  pc_write, ifid_write, idex_write, ifid_flush, idex_flush, halted,
               err_bits, stall_count
    );

    modport slave (
        input  clk_en, id_src1, id_src2, id_use1, id_use2, ex_is_load, ex_dest,
               ex_branch_taken, mem_req, mem_ready, halt_req,
        output pc_write, ifid_write, idex_write, ifid_flush, idex_flush, halted,
               err_bits, stall_count
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the scc IF/ID/EX pipeline.
//
// Ports:
//   clk_i  core clock
//   rst_i  synchronous active-high reset (priority over clk_en)
//   bus    pipeline_hazard_ctrl_if.slave (decode operands, EX status, memory
//          handshake in; write enables, flushes, halted, err_bits, stall_count out)
//
// Parameters:
//   FLUSH_DEPTH  cycles IF/ID stays flushed after a taken branch (1..7)
//   MEM_TIMEOUT  max stalled memory-wait cycles before a timeout error (2..255)
//
// Optional feature: define SCC_STALL_CNT_EN to build the stall-cycle counter;
// otherwise stall_count is tied to zero.
module pipeline_hazard_ctrl #(
    parameter int unsigned FLUSH_DEPTH = 1,
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input logic                   clk_i,
    input logic                   rst_i,
    pipeline_hazard_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StRun, StFlush, StMemWait, StHalt} state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;    // flush countdown or memory-wait count
    logic [1:0] err_q, err_d;
    logic       pc_w, ifid_w, idex_w, ifid_f, idex_f;
    logic       load_use;

    // No r0 exemption: a load to r0 still stalls a dependent reader.
    assign load_use = bus.ex_is_load &&
                      ((bus.id_use1 && (bus.id_src1 == bus.ex_dest)) ||
                       (bus.id_use2 && (bus.id_src2 == bus.ex_dest)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        pc_w    = 1'b0;
        ifid_w  = 1'b0;
        idex_w  = 1'b0;
        ifid_f  = 1'b0;
        idex_f  = 1'b0;
        if (!rst_i && bus.clk_en) begin
            unique case (state_q)
                StRun: begin
                    if (bus.halt_req) begin
                        state_d = StHalt;
                    end else if (bus.mem_req && !bus.mem_ready) begin
                        state_d = StMemWait;
                        cnt_d   = 8'd1;
                    end else if (bus.ex_branch_taken) begin
                        pc_w   = 1'b1;
                        ifid_w = 1'b1;
                        idex_w = 1'b1;
                        ifid_f = 1'b1;
                        idex_f = 1'b1;
                        if (FLUSH_DEPTH > 1) begin
                            state_d = StFlush;
                            cnt_d   = 8'(FLUSH_DEPTH - 1);
                        end
                    end else if (load_use) begin
                        // Hold PC and IF/ID, inject a bubble into ID/EX.
                        idex_w = 1'b1;
                        idex_f = 1'b1;
                    end else begin
                        pc_w   = 1'b1;
                        ifid_w = 1'b1;
                        idex_w = 1'b1;
                    end
                end
                StFlush: begin
                    pc_w   = 1'b1;
                    ifid_w = 1'b1;
                    idex_w = 1'b1;
                    ifid_f = 1'b1;
                    if (bus.ex_branch_taken) begin
                        err_d[1] = 1'b1;
                    end
                    if (cnt_q <= 8'd1) begin
                        state_d = StRun;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
                StMemWait: begin
                    if (bus.mem_ready) begin
                        pc_w    = 1'b1;
                        ifid_w  = 1'b1;
                        idex_w  = 1'b1;
                        state_d = StRun;
                        cnt_d   = 8'd0;
                    end else if (cnt_q >= 8'(MEM_TIMEOUT - 1)) begin
                        // Entry cycle counted as 1, so this is the MEM_TIMEOUT-th frozen cycle.
                        err_d[0] = 1'b1;
                        state_d  = StHalt;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                StHalt: begin
                    state_d = StHalt;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StRun;
            cnt_q   <= 8'd0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign bus.pc_write   = pc_w;
    assign bus.ifid_write = ifid_w;
    assign bus.idex_write = idex_w;
    assign bus.ifid_flush = ifid_f;
    assign bus.idex_flush = idex_f;
    assign bus.halted     = (state_q == StHalt);
    assign bus.err_bits   = err_q;

`ifdef SCC_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    always_comb begin
        stall_d = stall_q;
        if (!rst_i && bus.clk_en && !pc_w && (state_q != StHalt) && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_q <= 16'h0000;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign bus.stall_count = stall_q;
`else
    assign bus.stall_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench: u_a (FLUSH_DEPTH=3, MEM_TIMEOUT=16) covers hazards, flushes,
// memory waits and halt; u_b (FLUSH_DEPTH=1, MEM_TIMEOUT=4) covers the single
// cycle flush and the memory timeout. Both see the same stimulus.
module tb_pipeline_hazard_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if bus_a ();
    pipeline_hazard_ctrl_if bus_b ();

    pipeline_hazard_ctrl #(.FLUSH_DEPTH(3), .MEM_TIMEOUT(16)) u_a (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_a)
    );

    pipeline_hazard_ctrl #(.FLUSH_DEPTH(1), .MEM_TIMEOUT(4)) u_b (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus_b)
    );

    assign bus_b.clk_en          = bus_a.clk_en;
    assign bus_b.id_src1         = bus_a.id_src1;
    assign bus_b.id_src2         = bus_a.id_src2;
    assign bus_b.id_use1         = bus_a.id_use1;
    assign bus_b.id_use2         = bus_a.id_use2;
    assign bus_b.ex_is_load      = bus_a.ex_is_load;
    assign bus_b.ex_dest         = bus_a.ex_dest;
    assign bus_b.ex_branch_taken = bus_a.ex_branch_taken;
    assign bus_b.mem_req         = bus_a.mem_req;
    assign bus_b.mem_ready       = bus_a.mem_ready;
    assign bus_b.halt_req        = bus_a.halt_req;

    // {pc_write, ifid_write, idex_write, ifid_flush, idex_flush}
    logic [4:0] ctl_a, ctl_b;
    assign ctl_a = {bus_a.pc_write, bus_a.ifid_write, bus_a.idex_write,
                    bus_a.ifid_flush, bus_a.idex_flush};
    assign ctl_b = {bus_b.pc_write, bus_b.ifid_write, bus_b.idex_write,
                    bus_b.ifid_flush, bus_b.idex_flush};

`ifdef SCC_STALL_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [15:0] sc(input int n);
        return CntEn ? 16'(n) : 16'h0000;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clr();
        bus_a.id_src1         = 4'h0;
        bus_a.id_src2         = 4'h0;
        bus_a.id_use1         = 1'b0;
        bus_a.id_use2         = 1'b0;
        bus_a.ex_is_load      = 1'b0;
        bus_a.ex_dest         = 4'h0;
        bus_a.ex_branch_taken = 1'b0;
        bus_a.mem_req         = 1'b0;
        bus_a.mem_ready       = 1'b0;
        bus_a.halt_req        = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        bus_a.clk_en = 1'b1;
        clr();
        settle();
        chk("rst_ctl", 32'(ctl_a), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("idle_ctl", 32'(ctl_a), 32'b11100);
        chk("idle_err", 32'(bus_a.err_bits), 32'h0);
        chk("idle_stall", 32'(bus_a.stall_count), 32'(sc(0)));
        chk("idle_halted", 32'(bus_a.halted), 32'h0);
        tick();

        // Load-use on src2
        bus_a.ex_is_load = 1'b1; bus_a.ex_dest = 4'h3;
        bus_a.id_use2 = 1'b1; bus_a.id_src2 = 4'h3;
        settle();
        chk("lu_ctl", 32'(ctl_a & 5'b11001), 32'b00001);
        tick();
        clr();
        settle();
        chk("lu_after_ctl", 32'(ctl_a), 32'b11100);
        chk("lu_stall", 32'(bus_a.stall_count), 32'(sc(1)));
        // Matching src1 but not read, mismatching src2: no hazard
        bus_a.ex_is_load = 1'b1; bus_a.ex_dest = 4'h3;
        bus_a.id_src1 = 4'h3; bus_a.id_use1 = 1'b0;
        bus_a.id_src2 = 4'h4; bus_a.id_use2 = 1'b1;
        settle();
        chk("nohaz_ctl", 32'(ctl_a), 32'b11100);
        tick();
        // r0 is not exempt
        clr();
        bus_a.ex_is_load = 1'b1; bus_a.id_use1 = 1'b1;
        settle();
        chk("r0_ctl", 32'(ctl_a & 5'b11001), 32'b00001);
        tick();
        clr();
        settle();
        chk("r0_stall", 32'(bus_a.stall_count), 32'(sc(2)));

        // Branch, FLUSH_DEPTH=3, second branch while flushing
        bus_a.ex_branch_taken = 1'b1;
        settle();
        chk("br0_ctl", 32'(ctl_a & 5'b10011), 32'b10011);
        tick();
        settle();
        chk("br1_ctl", 32'(ctl_a), 32'b11110);
        tick();
        clr();
        settle();
        chk("br2_ctl", 32'(ctl_a), 32'b11110);
        chk("br2_err", 32'(bus_a.err_bits), 32'b10);
        tick();
        chk("br3_ctl", 32'(ctl_a), 32'b11100);

        // clk_en low mid-flush holds the remaining count
        bus_a.ex_branch_taken = 1'b1;
        settle();
        chk("ce_br0_ctl", 32'(ctl_a & 5'b10011), 32'b10011);
        tick();
        clr();
        settle();
        chk("ce_br1_ctl", 32'(ctl_a), 32'b11110);
        tick();
        bus_a.clk_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ce_off_ctl", 32'(ctl_a), 32'h0);
            tick();
        end
        bus_a.clk_en = 1'b1;
        settle();
        chk("ce_resume_ctl", 32'(ctl_a), 32'b11110);
        tick();
        chk("ce_done_ctl", 32'(ctl_a), 32'b11100);
        chk("ce_stall", 32'(bus_a.stall_count), 32'(sc(2)));

        // Memory wait: 5 frozen cycles then advance
        bus_a.mem_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("mw_ctl", 32'(ctl_a), 32'h0);
            tick();
        end
        bus_a.mem_ready = 1'b1;
        settle();
        chk("mw_ready_ctl", 32'(ctl_a), 32'b11100);
        tick();
        clr();
        settle();
        chk("mw_after_ctl", 32'(ctl_a), 32'b11100);
        chk("mw_stall", 32'(bus_a.stall_count), 32'(sc(7)));

        // Memory wait with a branch held in EX: flush only after release
        bus_a.mem_req = 1'b1; bus_a.ex_branch_taken = 1'b1;
        for (int i = 0; i < 5; i++) begin
            settle();
            chk("mwbr_ctl", 32'(ctl_a), 32'h0);
            tick();
        end
        bus_a.mem_ready = 1'b1;
        settle();
        chk("mwbr_ready_ctl", 32'(ctl_a), 32'b11100);
        tick();
        bus_a.mem_req = 1'b0; bus_a.mem_ready = 1'b0;
        settle();
        chk("mwbr_flush_ctl", 32'(ctl_a & 5'b10011), 32'b10011);
        tick();
        clr();
        settle();
        chk("mwbr_f1_ctl", 32'(ctl_a), 32'b11110);
        tick();
        chk("mwbr_f2_ctl", 32'(ctl_a), 32'b11110);
        tick();
        chk("mwbr_run_ctl", 32'(ctl_a), 32'b11100);
        chk("mwbr_stall", 32'(bus_a.stall_count), 32'(sc(12)));
        chk("mwbr_err", 32'(bus_a.err_bits), 32'b10);

        // Reset both, then FLUSH_DEPTH=1 and timeout on u_b
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("b_idle_ctl", 32'(ctl_b), 32'b11100);
        chk("b_idle_err", 32'(bus_b.err_bits), 32'h0);
        bus_a.ex_branch_taken = 1'b1;
        settle();
        chk("b_br_ctl", 32'(ctl_b & 5'b10011), 32'b10011);
        tick();
        clr();
        settle();
        chk("b_br_after_ctl", 32'(ctl_b), 32'b11100);
        tick();
        tick();
        bus_a.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("to_wait_ctl", 32'(ctl_b), 32'h0);
            chk("to_wait_halted", 32'(bus_b.halted), 32'h0);
            tick();
        end
        chk("to_halted", 32'(bus_b.halted), 32'h1);
        chk("to_err", 32'(bus_b.err_bits), 32'b01);
        chk("to_ctl", 32'(ctl_b), 32'h0);
        chk("to_stall", 32'(bus_b.stall_count), 32'(sc(4)));
        bus_a.mem_req = 1'b0;
        tick();
        bus_a.halt_req = 1'b1;
        tick();
        bus_a.halt_req = 1'b0;
        bus_a.mem_ready = 1'b1;
        settle();
        chk("to_persist_halted", 32'(bus_b.halted), 32'h1);
        chk("to_persist_stall", 32'(bus_b.stall_count), 32'(sc(4)));
        tick();
        clr();
        rst = 1'b1;
        settle();
        chk("to_rst_ctl", 32'(ctl_b), 32'h0);
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("to_rst_halted", 32'(bus_b.halted), 32'h0);
        chk("to_rst_err", 32'(bus_b.err_bits), 32'h0);
        chk("to_rst_stall", 32'(bus_b.stall_count), 32'(sc(0)));
        chk("to_rst_run_ctl", 32'(ctl_b), 32'b11100);

        // Halt request on u_a
        bus_a.halt_req = 1'b1;
        settle();
        chk("halt_req_ctl", 32'(ctl_a), 32'h0);
        tick();
        clr();
        settle();
        chk("halt_halted", 32'(bus_a.halted), 32'h1);
        chk("halt_ctl", 32'(ctl_a), 32'h0);
        chk("halt_stall", 32'(bus_a.stall_count), 32'(sc(1)));
        tick();
        tick();
        chk("halt_hold", 32'(bus_a.halted), 32'h1);
        chk("halt_hold_stall", 32'(bus_a.stall_count), 32'(sc(1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central stall/flush sequencer for the scc core's IF/ID/EX pipeline.
- Drives the write enables of the PC register and the IF/ID and ID/EX stage registers, plus their flush (bubble) controls.
- Inputs are decode operands, EX-stage load/branch status and data-memory handshake.
- Also owns sticky error reporting (feeds scc err_bits) and a stall-cycle counter.

Parameters:
- FLUSH_DEPTH, 1: cycles IF/ID stays flushed after a taken branch (1..7; covers fetch latency).
- MEM_TIMEOUT, 16: max cycles held in MEM_WAIT before a timeout error (2..255).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- clk_en  in  1  core clock enable
- id_src1  in  4  first source register of instruction in ID
- id_src2  in  4  second source register of instruction in ID
- id_use1  in  1  ID instruction reads id_src1
- id_use2  in  1  ID instruction reads id_src2
- ex_is_load  in  1  instruction in EX is a load
- ex_dest  in  4  destination register of the EX instruction
- ex_branch_taken  in  1  EX resolved a taken branch this cycle
- mem_req  in  1  data-memory access in progress
- mem_ready  in  1  data memory completes access this cycle
- halt_req  in  1  halt request (decoded halt instruction)
- pc_write  out  1  PC register update enable
- ifid_write  out  1  IF/ID register load enable
- idex_write  out  1  ID/EX register load enable
- ifid_flush  out  1  load NOP into IF/ID
- idex_flush  out  1  load NOP into ID/EX
- halted  out  1  core halted
- err_bits  out  2  sticky: [0] memory timeout, [1] branch-during-flush
- stall_count  out  16  saturating count of stalled cycles

Behaviour:
- Clocking and reset:
  - State, counters and err_bits are registered. Control outputs are combinational from current state and inputs.
  - rst=1: next state RUN, all counters 0, err_bits=0.
  - While rst=1, all write enables and flushes are 0. Reset has priority over clk_en.
  - clk_en=0: state and counters hold; all write enables and flushes are 0.
- States: RUN, FLUSH, MEM_WAIT, HALT.
- RUN default (no events): pc_write=ifid_write=idex_write=1, flushes 0, halted=0.
- RUN event priority, highest first:
  1. halt_req: all enables 0 this cycle; next state HALT.
  2. mem_req && !mem_ready: all enables 0, no flushes; next state MEM_WAIT, timeout count cleared to 1.
  3. ex_branch_taken: pc_write=1, ifid_flush=1, idex_flush=1. Next state FLUSH with flush count = FLUSH_DEPTH-1; if FLUSH_DEPTH=1, stay in RUN.
  4. Load-use hazard = ex_is_load && ((id_use1 && id_src1==ex_dest) || (id_use2 && id_src2==ex_dest)). No r0 exemption. Response: pc_write=0, ifid_write=0, idex_flush=1 for exactly this cycle; stay in RUN (the hazard clears once the load leaves EX).
- FLUSH:
  - pc_write=ifid_write=idex_write=1, ifid_flush=1.
  - Counter decrements each enabled cycle; at 1, return to RUN.
  - ex_branch_taken seen in FLUSH sets err_bits[1] and is otherwise ignored.
  - MEM and halt requests are deferred until RUN.
- MEM_WAIT:
  - All enables 0 while mem_ready=0; the timeout counter increments.
  - mem_ready=1: default RUN outputs this cycle (pipeline advances); next state RUN.
  - Counter reaching MEM_TIMEOUT with mem_ready=0: set err_bits[0]; next state HALT.
- HALT:
  - halted=1; all enables and flushes 0.
  - Exit only via rst. err_bits are sticky until rst.
- Branch vs memory wait: MEM_WAIT wins. EX is frozen, so ex_branch_taken stays asserted and is acted on in the first RUN cycle.
- stall_count: +1 on each clk_en cycle with pc_write=0 and state != HALT and rst=0. Saturates at 16'hFFFF.

Optional Feature:
- Macro: SCC_STALL_CNT_EN.
- Defined: stall_count operates as described above.
- Undefined: counter logic omitted; stall_count tied to 16'h0000. The port is always present.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, release, no events → pc_write=ifid_write=idex_write=1, flushes 0, err_bits=0, stall_count=0.
- Load-use: ex_is_load=1, ex_dest=4'h3, id_use2=1, id_src2=4'h3 for one cycle → that cycle pc_write=0, ifid_write=0, idex_flush=1; next cycle (ex_is_load=0) normal; stall_count=1.
- Branch with FLUSH_DEPTH=3: ex_branch_taken pulse → cycle 0: ifid_flush=idex_flush=1, pc_write=1; cycles 1-2: ifid_flush=1 only; cycle 3: RUN defaults. A second ex_branch_taken in cycle 1 → err_bits=2'b10.
- Memory wait: mem_req=1, mem_ready=0 for 5 cycles, then mem_ready=1 → 5 frozen cycles, advance on ready cycle, stall_count=5. Same stimulus with ex_branch_taken=1 held → flush occurs only after release.
- Timeout with MEM_TIMEOUT=4: mem_req=1, mem_ready never → err_bits[0]=1 and halted=1 after 4 wait cycles; halted persists until rst=1, after which err_bits=0.
- clk_en=0 for 3 cycles mid-FLUSH → state and count held, all enables 0; FLUSH resumes with the remaining count once clk_en=1.
